// File: rtl/ms_tick_timer_if.sv
// Control and status bundle for the millisecond countdown timer.
// start/stop are single-cycle requests with no back-pressure: every cycle a request is high counts as one request.
interface ms_tick_timer_if #(
    parameter int CNT_W = 16
);
    logic             start;
    logic             stop;
    logic [CNT_W-1:0] load_value;
    logic             tick;
    logic [CNT_W-1:0] remaining;
    logic             running;
    logic             done;
    logic             tick_lost;
    logic [1:0]       state_dbg;

    modport master (
        output start, stop, load_value,
        input  tick, remaining, running, done, tick_lost, state_dbg
    );

    modport slave (
        input  start, stop, load_value,
        output tick, remaining, running, done, tick_lost, state_dbg
    );
endinterface

// File: rtl/ms_tick_timer.sv
// Millisecond countdown timer driven by the divided slow clock.
// It synchronizes and edge-detects slow_clk into ticks, counts down and watches for a dead divider.
module ms_tick_timer #(
    parameter int CNT_W          = 16,
    parameter int TIMEOUT_CYCLES = 250000,
    parameter int WD_W           = 18
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           slow_clk,
    ms_tick_timer_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES);

    logic             s0, s1, s1_d;
    logic             tick_q;
    logic [WD_W-1:0]  wd_cnt;
    logic             tick_lost_q;
    logic [1:0]       state;
    logic [CNT_W-1:0] remaining_q;
    logic             done_q;
    logic             start_acc;

    // stop always wins over start in the same cycle
    assign start_acc = bus.start & ~bus.stop;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s0     <= 1'b0;
            s1     <= 1'b0;
            s1_d   <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            s0     <= slow_clk;
            s1     <= s0;
            s1_d   <= s1;
            tick_q <= s1 & ~s1_d;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wd_cnt      <= '0;
            tick_lost_q <= 1'b0;
        end else begin
            if (start_acc || tick_q) begin
                wd_cnt <= '0;
            end else if (wd_cnt != WD_MAX) begin
                wd_cnt <= wd_cnt + 1'b1;
            end
            if (start_acc) begin
                tick_lost_q <= 1'b0;
            end else if (wd_cnt == WD_MAX) begin
                tick_lost_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            remaining_q <= '0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus.stop) begin
                state <= IDLE;
            end else if (bus.start) begin
                // a start (or restart) ignores any tick arriving in the same cycle
                if (bus.load_value == '0) begin
                    remaining_q <= '0;
                    state       <= DONE;
                    done_q      <= 1'b1;
                end else begin
                    remaining_q <= bus.load_value;
                    state       <= RUN;
                end
            end else if (state == RUN && tick_q) begin
                if (remaining_q > CNT_W'(1)) begin
                    remaining_q <= remaining_q - 1'b1;
                end else begin
                    remaining_q <= '0;
                    state       <= DONE;
                    done_q      <= 1'b1;
                end
            end
        end
    end

    assign bus.tick      = tick_q;
    assign bus.remaining = remaining_q;
    assign bus.running   = (state == RUN);
    assign bus.done      = done_q;
    assign bus.tick_lost = tick_lost_q;
    assign bus.state_dbg = state;
endmodule

// File: tb/tb_ms_tick_timer.sv
// Self-checking bench for ms_tick_timer: a cycle model feeds an expected queue that is
// compared against the DUT every cycle, plus directed checks on the scenarios of interest.
module tb_ms_tick_timer;
  localparam int CNT_W = 16;
  localparam int T     = 20;
  localparam int WD_W  = 5;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic clock, reset, slow_clk;
  ms_tick_timer_if #(.CNT_W(CNT_W)) bus();

  ms_tick_timer #(.CNT_W(CNT_W), .TIMEOUT_CYCLES(T), .WD_W(WD_W)) dut (
    .clock(clock),
    .reset(reset),
    .slow_clk(slow_clk),
    .bus(bus.slave)
  );

  // clock/reset block
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // reference model state
  logic             m_s0, m_s1, m_s1d, m_tick, m_done, m_lost;
  logic [1:0]       m_state;
  logic [CNT_W-1:0] m_rem;
  int               m_wd;

  logic [31:0] exp_q[$];
  int n_vec, n_err;
  bit slow_auto;
  int phase;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_vec();
    return 32'({m_tick, m_rem, (m_state == ST_RUN), m_done, m_lost, m_state});
  endfunction

  function automatic logic [31:0] dut_vec();
    return 32'({bus.tick, bus.remaining, bus.running, bus.done, bus.tick_lost, bus.state_dbg});
  endfunction

  task automatic model_reset();
    m_s0 = 0; m_s1 = 0; m_s1d = 0; m_tick = 0; m_done = 0; m_lost = 0;
    m_state = ST_IDLE; m_rem = '0; m_wd = 0;
  endtask

  // one clock cycle: drive slow_clk, predict, push expected, compare at the falling edge
  task automatic step();
    logic n_tick, n_done, n_lost, acc;
    logic [1:0] n_state;
    logic [CNT_W-1:0] n_rem;
    int n_wd;
    if (slow_auto) begin
      slow_clk = ((phase % 8) < 4);
      phase++;
    end
    acc     = bus.start && !bus.stop;
    n_tick  = m_s1 && !m_s1d;
    n_wd    = (acc || m_tick) ? 0 : ((m_wd < T) ? m_wd + 1 : m_wd);
    n_lost  = acc ? 1'b0 : ((m_wd == T) ? 1'b1 : m_lost);
    n_state = m_state;
    n_rem   = m_rem;
    n_done  = 1'b0;
    if (bus.stop) begin
      n_state = ST_IDLE;
    end else if (bus.start) begin
      if (bus.load_value == 0) begin
        n_rem = '0; n_state = ST_DONE; n_done = 1'b1;
      end else begin
        n_rem = bus.load_value; n_state = ST_RUN;
      end
    end else if (m_state == ST_RUN && m_tick) begin
      if (m_rem > 1) n_rem = m_rem - 1;
      else begin
        n_rem = '0; n_state = ST_DONE; n_done = 1'b1;
      end
    end
    @(posedge clock);
    m_s1d = m_s1; m_s1 = m_s0; m_s0 = slow_clk; m_tick = n_tick;
    m_wd = n_wd; m_lost = n_lost; m_state = n_state; m_rem = n_rem; m_done = n_done;
    exp_q.push_back(model_vec());
    @(negedge clock);
    check("cycle", dut_vec(), exp_q.pop_front());
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pulse_start(input logic [CNT_W-1:0] v);
    bus.load_value = v;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic pulse_stop();
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
  endtask

  // advance until the DUT shows a tick (it is consumed at the next edge)
  task automatic wait_tick();
    bit got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      step();
      if (bus.tick) got = 1;
    end
    if (!got) check("wait_tick_timeout", 32'd0, 32'd1);
  endtask

  task automatic count_done(input int n, output int dones, output int runs);
    dones = 0; runs = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (bus.done) dones++;
      if (bus.running) runs++;
    end
  endtask

  task automatic async_reset();
    #2 reset = 1'b1;
    model_reset();
    #1;
    check("arst_running", 32'(bus.running), 32'd0);
    check("arst_remaining", 32'(bus.remaining), 32'd0);
    check("arst_state", 32'(bus.state_dbg), 32'(ST_IDLE));
    @(negedge clock);
    #2 reset = 1'b0;
  endtask

  int cnt, dones, runs;
  logic [CNT_W-1:0] last;

  initial begin
    n_vec = 0; n_err = 0; slow_auto = 0; phase = 0;
    reset = 1'b1; slow_clk = 1'b0;
    bus.start = 1'b0; bus.stop = 1'b0; bus.load_value = '0;
    model_reset();
    #1 check("reset_vec", dut_vec(), 32'd0);
    @(negedge clock);
    #2 reset = 1'b0;

    // tick latency, held high, tick rate
    steps(3);
    slow_clk = 1'b1;
    step(); check("tick_lat_n", 32'(bus.tick), 32'd0);
    step(); check("tick_lat_n1", 32'(bus.tick), 32'd0);
    step(); check("tick_lat_n2", 32'(bus.tick), 32'd1);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus.tick) cnt++;
    end
    check("tick_hold", 32'(cnt), 32'd0);
    slow_clk = 1'b0;
    steps(4);
    slow_auto = 1; phase = 0; cnt = 0;
    for (int i = 0; i < 64; i++) begin
      step();
      if (bus.tick) cnt++;
    end
    check("tick_count64", 32'(cnt), 32'd8);

    // countdown 3,2,1,0
    pulse_start(16'd3);
    check("cd_running", 32'(bus.running), 32'd1);
    check("cd_load", 32'(bus.remaining), 32'd3);
    last = 16'd3; dones = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (bus.remaining != last) begin
        check("cd_step", 32'(bus.remaining), 32'(last - 1'b1));
        last = bus.remaining;
      end
      if (bus.done) dones++;
    end
    check("cd_done_once", 32'(dones), 32'd1);
    check("cd_final_rem", 32'(bus.remaining), 32'd0);
    check("cd_final_state", 32'(bus.state_dbg), 32'(ST_DONE));

    // zero load
    pulse_start(16'd0);
    check("zero_done", 32'(bus.done), 32'd1);
    check("zero_running", 32'(bus.running), 32'd0);
    count_done(10, dones, runs);
    check("zero_never_run", 32'(runs), 32'd0);
    check("zero_no_repeat", 32'(dones), 32'd0);

    // restart
    pulse_start(16'd5);
    wait_tick(); step();
    wait_tick(); step();
    check("rs_after2", 32'(bus.remaining), 32'd3);
    pulse_start(16'd2);
    check("rs_reload", 32'(bus.remaining), 32'd2);
    wait_tick(); step();
    check("rs_one", 32'(bus.remaining), 32'd1);
    wait_tick(); step();
    check("rs_done", 32'(bus.done), 32'd1);

    // stop after one tick
    pulse_start(16'd4);
    wait_tick(); step();
    pulse_stop();
    check("stop_state", 32'(bus.state_dbg), 32'(ST_IDLE));
    check("stop_rem", 32'(bus.remaining), 32'd3);
    count_done(20, dones, runs);
    check("stop_no_done", 32'(dones), 32'd0);

    // start and stop together
    bus.load_value = 16'd7; bus.start = 1'b1; bus.stop = 1'b1;
    step();
    bus.start = 1'b0; bus.stop = 1'b0;
    check("ss_state", 32'(bus.state_dbg), 32'(ST_IDLE));
    check("ss_rem", 32'(bus.remaining), 32'd3);

    // start coinciding with a tick
    wait_tick();
    pulse_start(16'd9);
    check("st_tick_rem", 32'(bus.remaining), 32'd9);
    pulse_stop();

    // watchdog
    slow_auto = 0; slow_clk = 1'b0;
    steps(40);
    check("wd_set", 32'(bus.tick_lost), 32'd1);
    slow_auto = 1;
    steps(20);
    check("wd_sticky", 32'(bus.tick_lost), 32'd1);
    pulse_start(16'd6);
    check("wd_clear", 32'(bus.tick_lost), 32'd0);
    pulse_stop();
    steps(60);
    check("wd_normal", 32'(bus.tick_lost), 32'd0);

    // async reset mid-RUN
    pulse_start(16'd3);
    wait_tick(); step();
    check("ar_rem2", 32'(bus.remaining), 32'd2);
    async_reset();
    count_done(30, dones, runs);
    check("ar_no_done", 32'(dones), 32'd0);
    check("ar_no_run", 32'(runs), 32'd0);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
